// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data requesters onto one single-ported, fixed-latency memory.
// Define ARB_PERF_CNT_EN to add the perf_conflict / perf_if_wait counter ports.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_kill,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  output logic        busy
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_conflict,
  output logic [31:0] perf_if_wait
`endif
);

  localparam logic [3:0] CNT_INIT   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_t;

  state_t     state_q, state_d;
  owner_t     owner_q, owner_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] starve_q, starve_d;
  logic       st_q, st_d;            // in-flight data access is a store
  logic       kill_pend_q, kill_pend_d;

  logic       resp_cyc, issue_win, if_win, d_win;
  mem_req_t   req;

  // The response cycle doubles as an issue slot so accesses can run back-to-back.
  assign resp_cyc  = (state_q == BUSY) && (cnt_q == 4'd0);
  assign issue_win = !rst && ((state_q == IDLE) || resp_cyc);
  assign if_win    = issue_win && if_req && (!d_req || (starve_q == STARVE_LIM));
  assign d_win     = issue_win && d_req && !if_win;

  always_comb begin
    req = '0;
    if (if_win) begin
      req.addr = if_addr;
      req.be   = 4'hF;
    end else if (d_win) begin
      req.we    = d_we;
      req.addr  = d_addr;
      req.wdata = d_wdata;
      req.be    = d_be;
    end
  end

  assign if_gnt    = if_win;
  assign d_gnt     = d_win;
  assign mem_en    = if_win | d_win;
  assign mem_we    = req.we;
  assign mem_addr  = req.addr;
  assign mem_wdata = req.wdata;
  assign mem_be    = req.be;
  assign busy      = !rst && (state_q == BUSY);

  // A flushed fetch still occupies the memory; only its response is hidden.
  assign if_rvalid = !rst && resp_cyc && (owner_q == OWN_IF) && !kill_pend_q && !if_kill;
  assign d_rvalid  = !rst && resp_cyc && (owner_q == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid && !st_q) ? mem_rdata : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    st_d        = st_q;
    kill_pend_d = kill_pend_q;
    starve_d    = starve_q;

    if ((state_q == BUSY) && (owner_q == OWN_IF) && if_kill) kill_pend_d = 1'b1;

    if ((state_q == BUSY) && (cnt_q != 4'd0)) cnt_d = cnt_q - 4'd1;
    else if (resp_cyc)                        state_d = IDLE;

    // A new issue overrides the response-cycle return to IDLE and any kill just seen.
    if (if_win || d_win) begin
      state_d     = BUSY;
      cnt_d       = CNT_INIT;
      owner_d     = if_win ? OWN_IF : OWN_D;
      st_d        = d_win && d_we;
      kill_pend_d = 1'b0;
    end

    if (if_win)
      starve_d = '0;
    else if (d_win && if_req && (starve_q != STARVE_LIM))
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      starve_q    <= '0;
      owner_q     <= OWN_IF;
      st_q        <= 1'b0;
      kill_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      owner_q     <= owner_d;
      st_q        <= st_d;
      kill_pend_q <= kill_pend_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict <= '0;
      perf_if_wait  <= '0;
    end else begin
      if (issue_win && if_req && d_req) perf_conflict <= perf_conflict + 32'd1;
      if (if_req && !if_gnt)            perf_if_wait  <= perf_if_wait + 32'd1;
    end
  end
`endif

endmodule
